// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encodings and the default target address.
package i2c_pkg;

    localparam logic [6:0] DEFAULT_ADDRESS = 7'h40;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        REG       = 4'd3,
        REG_ACK   = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        RDATA_ACK = 4'd8
    } state_e;

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronizes SCL/SDA into clk_i and flags SCL edges, START and STOP.
module i2c_bus_monitor (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [1:0] r_scl_sync;
    logic [1:0] r_sda_sync;
    logic       r_scl_prev;
    logic       r_sda_prev;
    logic       w_scl;
    logic       w_sda;

    // Two-flop synchronizers plus one history flop per line for edge detection.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        // NOTE: reset is synchronous; idle bus level (both lines high) avoids false edges at release.
        if (!rst_ni) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[0], scl_i};
            r_sda_sync <= {r_sda_sync[0], sda_i};
            r_scl_prev <= r_scl_sync[1];
            r_sda_prev <= r_sda_sync[1];
        end
    end

    assign w_scl      = r_scl_sync[1];
    assign w_sda      = r_sda_sync[1];
    assign sda_o      = w_sda;
    assign scl_rise_o = w_scl & ~r_scl_prev;
    assign scl_fall_o = ~w_scl & r_scl_prev;
    assign start_o    = w_scl & r_sda_prev & ~w_sda;
    assign stop_o     = w_scl & ~r_sda_prev & w_sda;

endmodule

// File: rtl/i2c_target.sv
// I2C register-access target: pointer write, data writes, sequential reads.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDRESS = DEFAULT_ADDRESS
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       scl_i,
    inout  wire        sda_io,
    output logic [7:0] reg_addr_o,
    output logic [7:0] reg_wdata_o,
    output logic       reg_we_o,
    input  logic [7:0] reg_rdata_i,
    output logic       busy_o
);

    state_e     r_state;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic       r_we;
    logic       r_sda_oe;

    state_e     w_state_nx;
    logic [2:0] w_bit_cnt_nx;
    logic [7:0] w_shift_nx;
    logic [7:0] w_addr_nx;
    logic [7:0] w_wdata_nx;
    logic       w_we_nx;
    logic       w_sda_oe_nx;

    logic       w_sda_in;
    logic       w_sda;
    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_start;
    logic       w_stop;
    logic [7:0] w_byte;

    assign w_sda_in = sda_io;
    assign sda_io   = r_sda_oe ? 1'b0 : 1'bz;

    i2c_bus_monitor u_bus_monitor (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .scl_i      (scl_i),
        .sda_i      (w_sda_in),
        .sda_o      (w_sda),
        .scl_rise_o (w_scl_rise),
        .scl_fall_o (w_scl_fall),
        .start_o    (w_start),
        .stop_o     (w_stop)
    );

    // Byte as it will look once the bit arriving on this SCL rise is shifted in.
    assign w_byte = {r_shift[6:0], w_sda};

    // State register and datapath registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_addr    <= 8'h00;
            r_wdata   <= 8'h00;
            r_we      <= 1'b0;
            r_sda_oe  <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_bit_cnt <= w_bit_cnt_nx;
            r_shift   <= w_shift_nx;
            r_addr    <= w_addr_nx;
            r_wdata   <= w_wdata_nx;
            r_we      <= w_we_nx;
            r_sda_oe  <= w_sda_oe_nx;
        end
    end

    // Next-state and datapath decisions; bus conditions override bit handling.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        w_state_nx   = r_state;
        w_bit_cnt_nx = r_bit_cnt;
        w_shift_nx   = r_shift;
        w_addr_nx    = r_addr;
        w_wdata_nx   = r_wdata;
        w_we_nx      = 1'b0;
        w_sda_oe_nx  = r_sda_oe;

        if (w_stop) begin
            w_state_nx   = IDLE;
            w_bit_cnt_nx = 3'd0;
            w_sda_oe_nx  = 1'b0;
        end else if (w_start) begin
            w_state_nx   = ADDR;
            w_bit_cnt_nx = 3'd0;
            w_sda_oe_nx  = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_sda_oe_nx = 1'b0;
                end
                ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_nx   = w_byte;
                        w_bit_cnt_nx = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_state_nx = (w_byte[7:1] == ADDRESS) ? ADDR_ACK : IDLE;
                        end
                    end
                end
                // ACK states: first SCL fall starts the ACK, the second ends it.
                ADDR_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_sda_oe) begin
                            w_sda_oe_nx = 1'b1;
                        end else if (r_shift[0]) begin
                            w_state_nx   = RDATA;
                            w_bit_cnt_nx = 3'd0;
                            w_shift_nx   = {reg_rdata_i[6:0], 1'b1};
                            w_sda_oe_nx  = ~reg_rdata_i[7];
                        end else begin
                            w_state_nx   = REG;
                            w_bit_cnt_nx = 3'd0;
                            w_sda_oe_nx  = 1'b0;
                        end
                    end
                end
                REG: begin
                    if (w_scl_rise) begin
                        w_shift_nx   = w_byte;
                        w_bit_cnt_nx = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_addr_nx  = w_byte;
                            w_state_nx = REG_ACK;
                        end
                    end
                end
                REG_ACK, WDATA_ACK: begin
                    // Pointer advances in the cycle right after the write strobe.
                    if (r_we) begin
                        w_addr_nx = r_addr + 8'd1;
                    end
                    if (w_scl_fall) begin
                        if (!r_sda_oe) begin
                            w_sda_oe_nx = 1'b1;
                        end else begin
                            w_sda_oe_nx  = 1'b0;
                            w_state_nx   = WDATA;
                            w_bit_cnt_nx = 3'd0;
                        end
                    end
                end
                WDATA: begin
                    if (w_scl_rise) begin
                        w_shift_nx   = w_byte;
                        w_bit_cnt_nx = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_we_nx    = 1'b1;
                            w_wdata_nx = w_byte;
                            w_state_nx = WDATA_ACK;
                        end
                    end
                end
                // r_shift[7] always holds the next bit to drive.
                RDATA: begin
                    if (w_scl_fall) begin
                        if (r_bit_cnt == 3'd7) begin
                            w_sda_oe_nx  = 1'b0;
                            w_state_nx   = RDATA_ACK;
                            w_bit_cnt_nx = 3'd0;
                            w_addr_nx    = r_addr + 8'd1;
                        end else begin
                            w_sda_oe_nx  = ~r_shift[7];
                            w_shift_nx   = {r_shift[6:0], 1'b1};
                            w_bit_cnt_nx = r_bit_cnt + 3'd1;
                        end
                    end
                end
                RDATA_ACK: begin
                    if (w_scl_rise && w_sda) begin
                        w_state_nx = IDLE;
                    end else if (w_scl_fall) begin
                        w_state_nx   = RDATA;
                        w_bit_cnt_nx = 3'd0;
                        w_shift_nx   = {reg_rdata_i[6:0], 1'b1};
                        w_sda_oe_nx  = ~reg_rdata_i[7];
                    end
                end
                default: begin
                    w_state_nx  = IDLE;
                    w_sda_oe_nx = 1'b0;
                end
            endcase
        end
    end

    assign reg_addr_o  = r_addr;
    assign reg_wdata_o = r_wdata;
    assign reg_we_o    = r_we;
    assign busy_o      = (r_state != IDLE);

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged master plus a strobe recorder.
module tb_i2c_target;

    localparam int Q = 8;  // clk_i cycles per quarter SCL period

    logic       clk_i;
    logic       rst_ni;
    logic       scl_i;
    logic       m_sda_low;
    wire        sda;
    logic [7:0] reg_addr_o;
    logic [7:0] reg_wdata_o;
    logic       reg_we_o;
    logic [7:0] reg_rdata_i;
    logic       busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] s_addr[$];
    logic [7:0] s_data[$];

    pullup (sda);
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    // Register file model: contents are a fixed function of the address.
    assign reg_rdata_i = reg_addr_o ^ 8'h4A;

    i2c_target dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .scl_i       (scl_i),
        .sda_io      (sda),
        .reg_addr_o  (reg_addr_o),
        .reg_wdata_o (reg_wdata_o),
        .reg_we_o    (reg_we_o),
        .reg_rdata_i (reg_rdata_i),
        .busy_o      (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Record every write strobe cycle.
    always @(negedge clk_i) begin
        if (reg_we_o === 1'b1) begin
            s_addr.push_back(reg_addr_o);
            s_data.push_back(reg_wdata_o);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(posedge clk_i);
        #1;
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0; wait_q();
        scl_i = 1'b1;     wait_q();
        m_sda_low = 1'b1; wait_q();
        scl_i = 1'b0;     wait_q();
    endtask

    task automatic i2c_stop(input string tag);
        m_sda_low = 1'b1; wait_q();
        scl_i = 1'b1;     wait_q();
        m_sda_low = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;
        check(tag, busy_o, 1'b0);
        wait_q();
    endtask

    task automatic write_bit(input logic b);
        m_sda_low = ~b; wait_q();
        scl_i = 1'b1;   wait_q();
        wait_q();
        scl_i = 1'b0;   wait_q();
    endtask

    task automatic read_bit(output logic b);
        m_sda_low = 1'b0; wait_q();
        scl_i = 1'b1;     wait_q();
        b = sda;          wait_q();
        scl_i = 1'b0;     wait_q();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic a;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(a);
        ack = ~a;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(nack);
    endtask

    initial begin
        logic       ack;
        logic [7:0] rb;
        logic       b;
        logic [4:0] tail;

        rst_ni = 1'b0; scl_i = 1'b1; m_sda_low = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_busy", busy_o, 1'b0);
        check("reset_we", reg_we_o, 1'b0);
        check("reset_wdata", reg_wdata_o, 8'h00);
        check("reset_addr", reg_addr_o, 8'h00);
        check("reset_sda", sda, 1'b1);
        rst_ni = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;

        // Single write: pointer 0x06, data 0xAB.
        i2c_start();
        write_byte(8'h80, ack); check("w1_addr_ack", ack, 1'b1);
        check("w1_busy", busy_o, 1'b1);
        write_byte(8'h06, ack); check("w1_reg_ack", ack, 1'b1);
        write_byte(8'hAB, ack); check("w1_data_ack", ack, 1'b1);
        i2c_stop("w1_stop_idle");
        check("w1_strobes", s_addr.size(), 1);
        check("w1_we_addr", s_addr[0], 8'h06);
        check("w1_we_data", s_data[0], 8'hAB);
        check("w1_ptr", reg_addr_o, 8'h07);
        s_addr.delete(); s_data.delete();

        // Pointer wrap across two data bytes.
        i2c_start();
        write_byte(8'h80, ack); check("w2_addr_ack", ack, 1'b1);
        write_byte(8'hFF, ack); check("w2_reg_ack", ack, 1'b1);
        write_byte(8'h11, ack); check("w2_d0_ack", ack, 1'b1);
        write_byte(8'h22, ack); check("w2_d1_ack", ack, 1'b1);
        i2c_stop("w2_stop_idle");
        check("w2_strobes", s_addr.size(), 2);
        check("w2_s0_addr", s_addr[0], 8'hFF);
        check("w2_s0_data", s_data[0], 8'h11);
        check("w2_s1_addr", s_addr[1], 8'h00);
        check("w2_s1_data", s_data[1], 8'h22);
        check("w2_ptr", reg_addr_o, 8'h01);
        s_addr.delete(); s_data.delete();

        // Pointer write, repeated start, two-byte read (ACK then NACK).
        i2c_start();
        write_byte(8'h80, ack); check("r1_addr_ack", ack, 1'b1);
        write_byte(8'h10, ack); check("r1_reg_ack", ack, 1'b1);
        i2c_start();
        write_byte(8'h81, ack); check("r1_raddr_ack", ack, 1'b1);
        read_byte(1'b0, rb);    check("r1_byte0", rb, 8'h5A);
        read_byte(1'b1, rb);    check("r1_byte1", rb, 8'h5B);
        check("r1_nack_idle", busy_o, 1'b0);
        check("r1_nack_sda", sda, 1'b1);
        i2c_stop("r1_stop_idle");
        check("r1_ptr", reg_addr_o, 8'h12);
        check("r1_strobes", s_addr.size(), 0);

        // Foreign address byte 0x41: no ACK, no strobe, not busy.
        i2c_start();
        write_byte(8'h41, ack); check("na_ack", ack, 1'b0);
        check("na_busy", busy_o, 1'b0);
        i2c_stop("na_stop_idle");
        check("na_strobes", s_addr.size(), 0);

        // STOP after 4 data bits, then a full transaction.
        i2c_start();
        write_byte(8'h80, ack); check("p_addr_ack", ack, 1'b1);
        write_byte(8'h20, ack); check("p_reg_ack", ack, 1'b1);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
        i2c_stop("p_stop_idle");
        check("p_strobes", s_addr.size(), 0);
        i2c_start();
        write_byte(8'h80, ack); check("p2_addr_ack", ack, 1'b1);
        write_byte(8'h30, ack); check("p2_reg_ack", ack, 1'b1);
        write_byte(8'hC3, ack); check("p2_data_ack", ack, 1'b1);
        i2c_stop("p2_stop_idle");
        check("p2_strobes", s_addr.size(), 1);
        check("p2_we_addr", s_addr[0], 8'h30);
        check("p2_we_data", s_data[0], 8'hC3);
        s_addr.delete(); s_data.delete();

        // Reset pulse while the target drives a 0 data bit (0x0A from 0x40).
        i2c_start();
        write_byte(8'h80, ack); check("x_addr_ack", ack, 1'b1);
        write_byte(8'h40, ack); check("x_reg_ack", ack, 1'b1);
        i2c_start();
        write_byte(8'h81, ack); check("x_raddr_ack", ack, 1'b1);
        read_bit(b); read_bit(b); read_bit(b);
        check("x_driving", sda, 1'b0);
        @(posedge clk_i); #1 rst_ni = 1'b0;
        @(posedge clk_i); #1;
        check("x_rst_sda", sda, 1'b1);
        check("x_rst_busy", busy_o, 1'b0);
        check("x_rst_ptr", reg_addr_o, 8'h00);
        rst_ni = 1'b1;
        for (int i = 4; i >= 0; i--) begin
            read_bit(b);
            tail[i] = b;
        end
        check("x_tail_released", tail, 5'b11111);
        i2c_stop("x_stop_idle");
        check("x_strobes", s_addr.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
